kanji_glyph_fetch: RTL and testbench

- I/O-bus initiator for the MSX Kanji ROM port protocol (ports D8h–DBh).
- Given a 12-bit character code and a JIS level, it writes the low and high 6-bit address halves, then issues BYTES consecutive reads from the data port and streams the returned glyph bytes out.
- Sits between an on-screen display or font renderer and the internal I/O bus, as a master alongside the CPU I/O path.

---
 rtl/kanji_glyph_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_kanji_glyph_fetch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kanji_glyph_fetch.sv
`timescale 1ns/1ps
// Kanji ROM glyph fetcher: writes the two 6-bit address halves, then streams BYTES reads from the data port.
// Latency: with io_ack tied high, first data_valid 6 cycles after the req edge and done at 5+2*BYTES.
// Backpressure: each access holds the bus until io_ack; an access without io_ack for TIMEOUT cycles aborts the fetch.
module kanji_glyph_fetch #(
    parameter logic [7:0]  BASE_PORT = 8'hD8,
    parameter int unsigned BYTES     = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        level,
    input  logic [11:0] char_code,
    output logic        busy,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [4:0]  data_idx,
    output logic        done,
    output logic        error,
    output logic        io_iorq,
    output logic        io_wr,
    output logic        io_rd,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_dout,
    input  logic [7:0]  io_din,
    input  logic        io_ack
);

    // The wait counter only has to reach TIMEOUT-1 before the abort decision.
    localparam int              WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0]   WAIT_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
    localparam logic [4:0]      LAST_IDX  = 5'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_LO = 3'd1,
        WR_HI = 3'd2,
        RD    = 3'd3,
        GAP   = 3'd4,
        FIN   = 3'd5
    } state_t;

    typedef struct packed {
        logic        level;
        logic [11:0] code;
    } fetch_req_t;

    state_t        state;
    state_t        state_nxt;
    state_t        gap_next;
    fetch_req_t    req_q;
    fetch_req_t    req_src;
    logic [4:0]    rd_cnt;
    logic [WW-1:0] wait_cnt;
    logic          aborted;
    logic          in_access;
    logic          timeout_hit;

    // Port for the selected JIS level; hi selects the odd (high-address / data) port.
    function automatic logic [7:0] port_of(input logic lvl, input logic hi);
        return BASE_PORT + {6'b000000, lvl, hi};
    endfunction

    // Access-state decode and timeout detection for the current cycle.
    always_comb begin
        in_access   = (state == WR_LO) || (state == WR_HI) || (state == RD);
        timeout_hit = (TIMEOUT != 0) && in_access && !io_ack && (wait_cnt == WAIT_LAST);
        // WR_LO is entered straight from IDLE, before req_q has captured the request.
        req_src     = (state == IDLE) ? fetch_req_t'{level: level, code: char_code} : req_q;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; every access is followed by a bus-idle GAP cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:            if (req) state_nxt = WR_LO;
            WR_LO, WR_HI, RD: if (io_ack || timeout_hit) state_nxt = GAP;
            GAP:             state_nxt = aborted ? FIN : gap_next;
            FIN:             state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
    end

    // Request capture, read counter, wait counter and GAP successor bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q    <= '0;
            rd_cnt   <= '0;
            wait_cnt <= '0;
            aborted  <= 1'b0;
            gap_next <= IDLE;
        end else begin
            if (state == IDLE && req) begin
                req_q   <= req_src;
                rd_cnt  <= '0;
                aborted <= 1'b0;
            end

            // Counts cycles spent waiting inside one access; restarts on every new access.
            if (!in_access || state_nxt != state) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (in_access && state_nxt == GAP) begin
                aborted <= timeout_hit;
                case (state)
                    WR_LO:   gap_next <= WR_HI;
                    WR_HI:   gap_next <= RD;
                    default: gap_next <= (rd_cnt == LAST_IDX) ? FIN : RD;
                endcase
            end

            // Saturate on the final read so the index never wraps within a fetch.
            if (state == RD && io_ack && rd_cnt != LAST_IDX) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Glyph byte capture; data_valid lands in the GAP cycle after the acknowledged read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_idx   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= (state == RD) && io_ack;
            if (state == RD && io_ack) begin
                data_out <= io_din;
                data_idx <= rd_cnt;
            end
        end
    end

    // Status strobes, registered from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            busy  <= (state_nxt == WR_LO) || (state_nxt == WR_HI) ||
                     (state_nxt == RD)    || (state_nxt == GAP);
            done  <= (state_nxt == FIN);
            error <= (state_nxt == FIN) && aborted;
        end
    end

    // Bus drive for the state being entered; address and write data hold through GAP and IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_iorq <= 1'b0;
            io_wr   <= 1'b0;
            io_rd   <= 1'b0;
            io_addr <= '0;
            io_dout <= '0;
        end else begin
            case (state_nxt)
                WR_LO: begin
                    io_iorq <= 1'b1;
                    io_wr   <= 1'b1;
                    io_rd   <= 1'b0;
                    io_addr <= port_of(req_src.level, 1'b0);
                    io_dout <= {2'b00, req_src.code[5:0]};
                end
                WR_HI: begin
                    io_iorq <= 1'b1;
                    io_wr   <= 1'b1;
                    io_rd   <= 1'b0;
                    io_addr <= port_of(req_q.level, 1'b1);
                    io_dout <= {2'b00, req_q.code[11:6]};
                end
                RD: begin
                    io_iorq <= 1'b1;
                    io_wr   <= 1'b0;
                    io_rd   <= 1'b1;
                    io_addr <= port_of(req_q.level, 1'b1);
                    io_dout <= '0;
                end
                default: begin
                    io_iorq <= 1'b0;
                    io_wr   <= 1'b0;
                    io_rd   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kanji_glyph_fetch.sv
`timescale 1ns/1ps
// Directed bench for kanji_glyph_fetch: default instance plus a TIMEOUT=4 instance.
// Latency: fetch timing measured in cycles relative to the req edge.
// Backpressure: bench responders ack immediately, after 3 wait cycles, or never.
module tb_kanji_glyph_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        req_a, level_a, busy_a, data_valid_a, done_a, error_a;
    logic        io_iorq_a, io_wr_a, io_rd_a, io_ack_a;
    logic [11:0] code_a;
    logic [7:0]  data_out_a, io_addr_a, io_dout_a, io_din_a;
    logic [4:0]  data_idx_a;

    logic        req_b, level_b, busy_b, data_valid_b, done_b, error_b;
    logic        io_iorq_b, io_wr_b, io_rd_b, io_ack_b;
    logic [11:0] code_b;
    logic [7:0]  data_out_b, io_addr_b, io_dout_b, io_din_b;
    logic [4:0]  data_idx_b;

    kanji_glyph_fetch dut_a (
        .clk(clk), .reset(reset), .req(req_a), .level(level_a), .char_code(code_a),
        .busy(busy_a), .data_out(data_out_a), .data_valid(data_valid_a), .data_idx(data_idx_a),
        .done(done_a), .error(error_a), .io_iorq(io_iorq_a), .io_wr(io_wr_a), .io_rd(io_rd_a),
        .io_addr(io_addr_a), .io_dout(io_dout_a), .io_din(io_din_a), .io_ack(io_ack_a)
    );

    kanji_glyph_fetch #(.TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .level(level_b), .char_code(code_b),
        .busy(busy_b), .data_out(data_out_b), .data_valid(data_valid_b), .data_idx(data_idx_b),
        .done(done_b), .error(error_b), .io_iorq(io_iorq_b), .io_wr(io_wr_b), .io_rd(io_rd_b),
        .io_addr(io_addr_b), .io_dout(io_dout_b), .io_din(io_din_b), .io_ack(io_ack_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observations for instance A.
    int         mode_a = 0;
    int         nv, nw, rd_ok, rd_bad, idx_mis, dmis, done_cnt, err_cnt, stable_bad;
    int         first_rel, last_rel, done_rel, wcnt_a;
    logic       busy_at_done, prev_iorq_a;
    logic [7:0] wr_addr [4];
    logic [7:0] wr_dat  [4];
    logic [7:0] exp_q   [$];
    logic [7:0] exp_rd_addr;
    logic [17:0] snap_a;

    // Observations for instance B.
    int nvb, doneb_cnt, errb_cnt, both_b, cur_len, last_len, doneb_rel, rdb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr_a();
        nv = 0; nw = 0; rd_ok = 0; rd_bad = 0; idx_mis = 0; dmis = 0;
        done_cnt = 0; err_cnt = 0; stable_bad = 0;
        first_rel = -1; last_rel = -1; done_rel = -1; busy_at_done = 1'bx;
        exp_q.delete();
    endtask

    task automatic start_a(input logic lvl, input logic [11:0] code);
        clr_a();
        level_a = lvl;
        code_a  = code;
        req_a   = 1'b1;
        base    = cyc + 1;
        tick(1);
        req_a   = 1'b0;
    endtask

    task automatic wait_done_a(input int maxc, input string tag);
        for (int i = 0; i < maxc; i++) begin
            tick(1);
            if (done_a) break;
        end
        chk(tag, 32'(done_a), 32'd1);
    endtask

    // Responder A: mode 0 acks every cycle, mode 1 acks in the 4th cycle of each access.
    initial begin
        io_ack_a = 1'b0;
        io_din_a = 8'h00;
        wcnt_a   = 0;
        forever begin
            @(negedge clk);
            if (io_iorq_a) wcnt_a++;
            else           wcnt_a = 0;
            if (io_iorq_a) begin
                if (wcnt_a == 1) snap_a = {io_addr_a, io_dout_a, io_wr_a, io_rd_a};
                else if (snap_a !== {io_addr_a, io_dout_a, io_wr_a, io_rd_a}) stable_bad++;
            end
            io_ack_a = (mode_a == 0) ? 1'b1 : (io_iorq_a && wcnt_a == 4);
            io_din_a = 8'($urandom);
            if (io_ack_a && io_iorq_a && io_rd_a) exp_q.push_back(io_din_a);
        end
    end

    // Monitor A: data stream, bus accesses and strobes.
    initial begin
        prev_iorq_a = 1'b0;
        clr_a();
        forever begin
            @(negedge clk);
            if (data_valid_a) begin
                if (nv == 0) first_rel = cyc - base + 1;
                last_rel = cyc - base + 1;
                if (data_idx_a !== 5'(nv)) idx_mis++;
                if (exp_q.size() == 0) dmis++;
                else if (data_out_a !== exp_q.pop_front()) dmis++;
                nv++;
            end
            if (done_a) begin
                done_cnt++;
                done_rel     = cyc - base + 1;
                busy_at_done = busy_a;
            end
            if (error_a) err_cnt++;
            if (io_iorq_a && !prev_iorq_a) begin
                if (io_wr_a && nw < 4) begin
                    wr_addr[nw] = io_addr_a;
                    wr_dat[nw]  = io_dout_a;
                    nw++;
                end
                if (io_rd_a) begin
                    if (io_addr_a == exp_rd_addr) rd_ok++;
                    else                          rd_bad++;
                end
            end
            prev_iorq_a = io_iorq_a;
        end
    end

    // Responder B: acks writes and the first four reads, never the fifth.
    initial begin
        io_ack_b = 1'b0;
        io_din_b = 8'h00;
        rdb      = 0;
        forever begin
            @(negedge clk);
            if (io_iorq_b && io_rd_b) io_ack_b = (rdb < 4);
            else                      io_ack_b = io_iorq_b;
            if (io_ack_b && io_rd_b) rdb++;
            io_din_b = 8'($urandom);
        end
    end

    // Monitor B: valid count, read strobe length, done/error alignment.
    initial begin
        nvb = 0; doneb_cnt = 0; errb_cnt = 0; both_b = 0; cur_len = 0; last_len = 0; doneb_rel = -1;
        forever begin
            @(negedge clk);
            if (data_valid_b) nvb++;
            if (done_b) begin
                doneb_cnt++;
                doneb_rel = cyc - base + 1;
                if (error_b) both_b++;
            end
            if (error_b) errb_cnt++;
            if (io_rd_b) cur_len++;
            else if (cur_len > 0) begin
                last_len = cur_len;
                cur_len  = 0;
            end
        end
    end

    initial begin
        reset = 1'b1;
        req_a = 1'b0; level_a = 1'b0; code_a = 12'h000;
        req_b = 1'b0; level_b = 1'b0; code_b = 12'h000;
        exp_rd_addr = 8'hD9;
        #2 reset = 1'b0;
        #1;
        chk("reset_ctrl", 32'({busy_a, data_valid_a, done_a, error_a, io_iorq_a, io_wr_a, io_rd_a, data_idx_a}), 32'd0);
        chk("reset_data", 32'({io_addr_a, io_dout_a, data_out_a}), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(2);

        // Fetch 1: level 1 ports, immediate ack, a mid-fetch req that must be ignored.
        mode_a = 0;
        exp_rd_addr = 8'hD9;
        start_a(1'b0, 12'hFC1);
        chk("f1_busy", 32'(busy_a), 32'd1);
        tick(30);
        req_a = 1'b1;
        tick(1);
        req_a = 1'b0;
        wait_done_a(100, "f1_done_seen");
        chk("f1_wr_cnt",   32'(nw), 32'd2);
        chk("f1_wr0_addr", 32'(wr_addr[0]), 32'hD8);
        chk("f1_wr0_dat",  32'(wr_dat[0]),  32'h01);
        chk("f1_wr1_addr", 32'(wr_addr[1]), 32'hD9);
        chk("f1_wr1_dat",  32'(wr_dat[1]),  32'h3F);
        chk("f1_rd_ok",    32'(rd_ok), 32'd32);
        chk("f1_rd_bad",   32'(rd_bad), 32'd0);
        chk("f1_nvalid",   32'(nv), 32'd32);
        chk("f1_idx",      32'(idx_mis), 32'd0);
        chk("f1_data",     32'(dmis), 32'd0);
        chk("f1_first_dv", 32'(first_rel), 32'd6);
        chk("f1_last_dv",  32'(last_rel), 32'd68);
        chk("f1_done_cyc", 32'(done_rel), 32'd69);
        chk("f1_fin_busy", 32'(busy_at_done), 32'd0);
        chk("f1_error",    32'(err_cnt), 32'd0);

        // req held in FIN is ignored; still high one cycle later it starts fetch 2.
        req_a = 1'b1;
        tick(1);
        chk("fin_req_ignored", 32'({busy_a, io_iorq_a}), 32'd0);
        clr_a();
        level_a = 1'b1;
        code_a  = 12'h041;
        mode_a  = 1;
        exp_rd_addr = 8'hDB;
        base = cyc + 1;
        tick(1);
        req_a = 1'b0;
        chk("f2_start_busy", 32'(busy_a), 32'd1);
        wait_done_a(400, "f2_done_seen");
        chk("f2_wr0_addr", 32'(wr_addr[0]), 32'hDA);
        chk("f2_wr0_dat",  32'(wr_dat[0]),  32'h01);
        chk("f2_wr1_addr", 32'(wr_addr[1]), 32'hDB);
        chk("f2_wr1_dat",  32'(wr_dat[1]),  32'h01);
        chk("f2_rd_ok",    32'(rd_ok), 32'd32);
        chk("f2_rd_bad",   32'(rd_bad), 32'd0);
        chk("f2_nvalid",   32'(nv), 32'd32);
        chk("f2_idx",      32'(idx_mis), 32'd0);
        chk("f2_data",     32'(dmis), 32'd0);
        chk("f2_stable",   32'(stable_bad), 32'd0);
        chk("f2_error",    32'(err_cnt), 32'd0);
        tick(2);

        // Fetch 3 on the TIMEOUT=4 instance: fifth read is never acknowledged.
        req_b = 1'b1;
        base  = cyc + 1;
        tick(1);
        req_b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done_b) break;
            tick(1);
        end
        chk("to_done_seen", 32'(done_b), 32'd1);
        tick(2);
        chk("to_nvalid",   32'(nvb), 32'd4);
        chk("to_strobe",   32'(last_len), 32'd4);
        chk("to_done_err", 32'({8'(doneb_cnt), 8'(errb_cnt), 8'(both_b)}), 32'h010101);
        chk("to_done_cyc", 32'(doneb_rel), 32'd18);
        chk("to_idle",     32'({busy_b, io_iorq_b, io_rd_b}), 32'd0);

        // Fetch 4: reset during read 10, then a clean restart.
        mode_a = 0;
        exp_rd_addr = 8'hD9;
        start_a(1'b0, 12'h123);
        for (int i = 0; i < 60; i++) begin
            if (io_rd_a && nv == 10) break;
            tick(1);
        end
        chk("rst_rd10_reached", 32'(nv), 32'd10);
        reset = 1'b0;
        #1;
        chk("rst_async", 32'({io_iorq_a, io_rd_a, busy_a}), 32'd0);
        tick(3);
        chk("rst_no_done", 32'({8'(done_cnt), 8'(err_cnt)}), 32'd0);
        reset = 1'b1;
        tick(2);
        start_a(1'b0, 12'h2A5);
        wait_done_a(100, "f5_done_seen");
        chk("f5_wr0_dat",  32'(wr_dat[0]), 32'h25);
        chk("f5_wr1_dat",  32'(wr_dat[1]), 32'h0A);
        chk("f5_nvalid",   32'(nv), 32'd32);
        chk("f5_idx",      32'(idx_mis), 32'd0);
        chk("f5_data",     32'(dmis), 32'd0);
        chk("f5_first_dv", 32'(first_rel), 32'd6);
        chk("f5_done_cyc", 32'(done_rel), 32'd69);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
